// File: rtl/elastic_fifo_buffer_pkg.sv
// Shared definitions for the elastic FIFO buffer: default payload width,
// channel bundle type and index-width helper for arbitrary depths.
package elastic_pkg;

  localparam int DATA_WIDTH_DEF = 32;

  typedef struct packed {
    logic                      valid;
    logic                      stop;
    logic [DATA_WIDTH_DEF-1:0] data;
  } elastic_ch_t;

  // A depth of 1 still needs a 1-bit index so the ports stay legal.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/elastic_fifo_buffer_if.sv
// Valid/stop elastic channel through the buffer: upstream side (valid_input,
// stop_input, data_input) and downstream side (valid_output, stop_output, data_output).
interface elastic_fifo_buffer_if #(
  parameter int DATA_WIDTH = elastic_pkg::DATA_WIDTH_DEF
);
  logic                  valid_input;
  logic                  stop_input;
  logic [DATA_WIDTH-1:0] data_input;
  logic                  valid_output;
  logic                  stop_output;
  logic [DATA_WIDTH-1:0] data_output;

  modport slave (
    input  valid_input, data_input, stop_output,
    output stop_input, valid_output, data_output
  );

  modport master (
    output valid_input, data_input, stop_output,
    input  stop_input, valid_output, data_output
  );
endinterface

// File: rtl/elastic_fifo_buffer_ctrl.sv
// Index/count bookkeeping for the elastic FIFO: wrap-by-compare indices,
// single-assignment occupancy counter, full/empty flags from registered count.
module elastic_fifo_ctrl
  import elastic_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1),
  parameter int IDX_W = idx_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  output logic [IDX_W-1:0] rd_idx_o,
  output logic [IDX_W-1:0] wr_idx_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(DEPTH - 1)) ? '0 : idx + IDX_W'(1);
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    rd_idx_d = pop_ok  ? idx_inc(rd_idx_q) : rd_idx_q;
    wr_idx_d = push_ok ? idx_inc(wr_idx_q) : wr_idx_q;
    count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    // Flush discards any same-cycle push/pop.
    if (flush_i) begin
      rd_idx_d = '0;
      wr_idx_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_idx_q <= '0;
      wr_idx_q <= '0;
      count_q  <= '0;
    end else begin
      rd_idx_q <= rd_idx_d;
      wr_idx_q <= wr_idx_d;
      count_q  <= count_d;
    end
  end

  assign rd_idx_o = rd_idx_q;
  assign wr_idx_o = wr_idx_q;
  assign count_o  = count_q;

endmodule

// File: rtl/elastic_fifo_buffer.sv
// Elastic valid/stop channel buffer of arbitrary depth with flush and status.
// Optional zero-latency empty-buffer bypass under ELASTIC_FIFO_BYPASS_EN.
module elastic_fifo_buffer
  import elastic_pkg::*;
#(
  parameter  int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter  int DEPTH          = 4,
  parameter  int ALMOST_FULL_TH = DEPTH - 1,
  localparam int CNT_W          = $clog2(DEPTH + 1),
  localparam int IDX_W          = idx_width(DEPTH)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      flush,
  elastic_fifo_buffer_if.slave      ch,
  output logic [CNT_W-1:0]          occupancy,
  output logic                      almost_full
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [IDX_W-1:0]      rd_idx, wr_idx;
  logic [CNT_W-1:0]      count;
  logic                  full, empty;
  logic                  wr_req, rd_req, wr_en;

  elastic_fifo_ctrl #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W),
    .IDX_W (IDX_W)
  ) u_ctrl (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush_i  (flush),
    .push_i   (wr_req),
    .pop_i    (rd_req),
    .rd_idx_o (rd_idx),
    .wr_idx_o (wr_idx),
    .count_o  (count),
    .full_o   (full),
    .empty_o  (empty)
  );

`ifdef ELASTIC_FIFO_BYPASS_EN
  logic byp;
  assign byp             = empty & ~flush;
  assign ch.valid_output = byp ? ch.valid_input : ~empty;
  assign ch.data_output  = byp ? ch.data_input  : mem_q[rd_idx];
  // A bypassed token that leaves this cycle must not also be stored.
  assign wr_req          = ch.valid_input & ~(byp & ~ch.stop_output);
`else
  assign ch.valid_output = ~empty;
  assign ch.data_output  = mem_q[rd_idx];
  assign wr_req          = ch.valid_input;
`endif

  // Pops only ever drain stored entries; empty-buffer stop_output is ignored.
  assign rd_req = ~empty & ~ch.stop_output;
  assign wr_en  = wr_req & ~full & ~flush;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= ch.data_input;
  end

  assign ch.stop_input = full;
  assign occupancy     = count;
  assign almost_full   = (count >= CNT_W'(ALMOST_FULL_TH));

`ifndef SYNTHESIS
  a_count_bound : assert property (@(posedge clk) disable iff (!reset_n)
    count <= CNT_W'(DEPTH));
  a_hold_stable : assert property (@(posedge clk) disable iff (!reset_n)
    (ch.valid_output && ch.stop_output && !flush) |=> $stable(ch.data_output));
`endif

endmodule

// File: tb/tb_elastic_fifo_buffer.sv
// Directed bench for elastic_fifo_buffer (DEPTH=3, DATA_WIDTH=8): vector table
// plus wrap, async-reset and (if ELASTIC_FIFO_BYPASS_EN) bypass sequences.
module tb_elastic_fifo_buffer;
  localparam int DW = 8;
  localparam int DP = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       flush = 1'b0;
  logic [1:0] occupancy;
  logic       almost_full;
  int         n_tests = 0;
  int         n_fail  = 0;

  elastic_fifo_buffer_if #(.DATA_WIDTH(DW)) bus ();

  elastic_fifo_buffer #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush       (flush),
    .ch          (bus.slave),
    .occupancy   (occupancy),
    .almost_full (almost_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          fl;
    logic          vi;
    logic [DW-1:0] di;
    logic          so;
    logic          vo;
    logic [DW-1:0] dq;
    logic          si;
    logic [1:0]    occ;
    logic          af;
  } vec_t;

  vec_t vt [24];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic vi, input logic [DW-1:0] di, input logic so);
    flush = fl;
    bus.valid_input = vi;
    bus.data_input = di;
    bus.stop_output = so;
  endtask

  initial begin
    int sent, got;
    logic          ev;
    logic [DW-1:0] ed;

    // Inputs/outputs observed before the edge that consumes the inputs.
    //            fl vi di     so  vo dq     si occ af
    vt[0]  = '{0, 1, 8'h11, 1,  0, 8'h00, 0, 0, 0};  // fill
    vt[1]  = '{0, 1, 8'h22, 1,  1, 8'h11, 0, 1, 0};
    vt[2]  = '{0, 1, 8'h33, 1,  1, 8'h11, 0, 2, 1};
    vt[3]  = '{0, 0, 8'h00, 0,  1, 8'h11, 1, 3, 1};  // full, drain
    vt[4]  = '{0, 0, 8'h00, 0,  1, 8'h22, 0, 2, 1};
    vt[5]  = '{0, 0, 8'h00, 0,  1, 8'h33, 0, 1, 0};
    vt[6]  = '{0, 0, 8'h00, 1,  0, 8'h00, 0, 0, 0};
    vt[7]  = '{0, 1, 8'hA1, 1,  0, 8'h00, 0, 0, 0};  // push+pop at occ 2
    vt[8]  = '{0, 1, 8'hA2, 1,  1, 8'hA1, 0, 1, 0};
    vt[9]  = '{0, 1, 8'h44, 0,  1, 8'hA1, 0, 2, 1};
    vt[10] = '{0, 0, 8'h00, 0,  1, 8'hA2, 0, 2, 1};
    vt[11] = '{0, 0, 8'h00, 0,  1, 8'h44, 0, 1, 0};
    vt[12] = '{0, 0, 8'h00, 1,  0, 8'h00, 0, 0, 0};
    vt[13] = '{0, 1, 8'hB1, 1,  0, 8'h00, 0, 0, 0};  // full while popping
    vt[14] = '{0, 1, 8'hB2, 1,  1, 8'hB1, 0, 1, 0};
    vt[15] = '{0, 1, 8'hB3, 1,  1, 8'hB1, 0, 2, 1};
    vt[16] = '{0, 1, 8'hBB, 0,  1, 8'hB1, 1, 3, 1};
    vt[17] = '{0, 0, 8'h00, 1,  1, 8'hB2, 0, 2, 1};
    vt[18] = '{1, 1, 8'h55, 0,  1, 8'hB2, 0, 2, 1};  // flush + push
    vt[19] = '{0, 0, 8'h00, 1,  0, 8'h00, 0, 0, 0};
    vt[20] = '{0, 0, 8'h00, 1,  0, 8'h00, 0, 0, 0};
    vt[21] = '{0, 1, 8'hC1, 1,  0, 8'h00, 0, 0, 0};  // resumes after flush
    vt[22] = '{0, 0, 8'h00, 0,  1, 8'hC1, 0, 1, 0};
    vt[23] = '{0, 0, 8'h00, 1,  0, 8'h00, 0, 0, 0};

    drive(0, 0, '0, 0);
    @(posedge clk); #1;
    chk("rst.vo",  bus.valid_output, 0);
    chk("rst.si",  bus.stop_input, 0);
    chk("rst.occ", occupancy, 0);
    chk("rst.af",  almost_full, 0);
    reset_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      drive(vt[i].fl, vt[i].vi, vt[i].di, vt[i].so);
      ev = vt[i].vo;
      ed = vt[i].dq;
`ifdef ELASTIC_FIFO_BYPASS_EN
      if (vt[i].occ == 0 && !vt[i].fl) begin
        ev = vt[i].vi;
        ed = vt[i].di;
      end
`endif
      #3;
      chk($sformatf("v%0d.vo", i), bus.valid_output, ev);
      if (ev) chk($sformatf("v%0d.dq", i), bus.data_output, ed);
      chk($sformatf("v%0d.si", i),  bus.stop_input, vt[i].si);
      chk($sformatf("v%0d.occ", i), occupancy, vt[i].occ);
      chk($sformatf("v%0d.af", i),  almost_full, vt[i].af);
      @(posedge clk); #1;
    end

    // Continuous streaming of 0..9 through a depth-3 ring.
    sent = 0;
    got  = 0;
    for (int c = 0; c < 40 && got < 10; c++) begin
      drive(0, sent < 10, DW'(sent), 0);
      #3;
      if (bus.valid_output) begin
        chk("wrap.data", bus.data_output, got);
        got++;
      end
      if (bus.valid_input && !bus.stop_input) sent++;
      chk("wrap.widx", dut.u_ctrl.wr_idx_q < 2'd3, 1);
      chk("wrap.ridx", dut.u_ctrl.rd_idx_q < 2'd3, 1);
      @(posedge clk); #1;
    end
    chk("wrap.count", got, 10);
    drive(0, 0, '0, 1);
    #3;
    chk("wrap.empty", bus.valid_output, 0);
    @(posedge clk); #1;

    // Async reset between edges with two entries in flight.
    drive(0, 1, 8'hE1, 1);
    @(posedge clk); #1;
    drive(0, 1, 8'hE2, 1);
    @(posedge clk); #1;
    drive(0, 0, '0, 1);
    chk("pre_rst.occ", occupancy, 2);
    #2 reset_n = 1'b0;
    #1;
    chk("arst.vo",  bus.valid_output, 0);
    chk("arst.si",  bus.stop_input, 0);
    chk("arst.occ", occupancy, 0);
    chk("arst.af",  almost_full, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    drive(0, 1, 8'hF1, 1);
    @(posedge clk); #1;
    drive(0, 0, '0, 1);
    #3;
    chk("post_rst.vo",  bus.valid_output, 1);
    chk("post_rst.dq",  bus.data_output, 8'hF1);
    chk("post_rst.occ", occupancy, 1);
    drive(0, 0, '0, 0);
    @(posedge clk); #1;

`ifdef ELASTIC_FIFO_BYPASS_EN
    drive(0, 1, 8'h66, 0);
    #3;
    chk("byp.vo", bus.valid_output, 1);
    chk("byp.dq", bus.data_output, 8'h66);
    @(posedge clk); #1;
    drive(0, 0, '0, 0);
    #3;
    chk("byp.occ", occupancy, 0);
    chk("byp.after_vo", bus.valid_output, 0);
    @(posedge clk); #1;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/elastic_fifo_buffer.md
Name: elastic_fifo_buffer

Overview:
- Parametrised successor to the fixed-size elastic buffer used between PEs and router ports in the elastic CGRA simulator.
- Valid/stop elastic channel buffer with:
  - arbitrary depth, including non-power-of-two;
  - correct simultaneous push/pop accounting;
  - synchronous flush;
  - occupancy and almost-full status.
- Sits on every elastic link; the config/flush path drives `flush` between kernel runs.

Parameters:
- DATA_WIDTH, 32, payload width in bits.
- DEPTH, 4, number of entries; legal range >= 1, any integer.
- ALMOST_FULL_TH, DEPTH-1, `almost_full` asserts when occupancy >= this value; legal range 1..DEPTH.
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived; do not override).
- IDX_W, (DEPTH>1 ? $clog2(DEPTH) : 1), read/write index width (derived).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear of all entries; takes priority over push and pop.
- valid_input  input  1  upstream holds valid data.
- stop_input  output  1  backpressure to upstream; high when full.
- data_input  input  DATA_WIDTH  upstream payload.
- valid_output  output  1  buffer presents valid data downstream.
- stop_output  input  1  downstream backpressure.
- data_output  output  DATA_WIDTH  head-of-queue payload.
- occupancy  output  CNT_W  current entry count, 0..DEPTH.
- almost_full  output  1  occupancy >= ALMOST_FULL_TH.

Behaviour:
- Reset (reset_n low, asynchronous):
  - read index = 0, write index = 0, count = 0.
  - valid_output = 0, stop_input = 0, occupancy = 0, almost_full = 0.
  - The data array is not reset; data_output is don't-care while valid_output = 0.
- Events:
  - push = valid_input & !stop_input.
  - pop = valid_output & !stop_output.
- Count update uses a single assignment: count_next = count + push - pop. Push and pop in the same cycle leave count unchanged. Separate conflicting nonblocking writes are forbidden.
- Index wrap:
  - An index at DEPTH-1 increments to 0 by explicit compare, never by natural overflow.
  - DEPTH=1 degenerates to a single-entry register.
- Output decodes:
  - stop_input = (count == DEPTH). Registered state only; there is no combinational path from stop_output to stop_input.
  - Consequence: a full buffer refuses a push even while popping that cycle.
  - valid_output = (count != 0).
  - data_output = mem[read index].
- Latency: data pushed in cycle N is visible on data_output in cycle N+1 (baseline, without bypass).
- Empty boundary: pop is impossible; stop_output is ignored.
- Full boundary: push is impossible; valid_input is ignored and data_input is not written.
- Flush:
  - At the clock edge, indices and count return to 0.
  - Any concurrent push or pop in that cycle is discarded.
  - Outputs follow the reset values from the next cycle.
- Reset mid-operation: all in-flight entries are lost; the block resumes empty.
- Status outputs: occupancy = count; almost_full is combinational from count.
- Assertions (simulation only):
  - count never exceeds DEPTH.
  - data_output is stable while valid_output & stop_output.

Optional Feature:
- Macro: ELASTIC_FIFO_BYPASS_EN.
- Defined, buffer empty and not flushing:
  - valid_output = valid_input; data_output = data_input.
  - If stop_output = 0, the token passes combinationally with 0-cycle latency and is not written.
  - If stop_output = 1, the token is written normally.
  - stop_input stays the registered full flag.
- Undefined: minimum latency is 1 cycle; no combinational path from input to output.

Decomposition:
- Shared package elastic_pkg:
  - default DATA_WIDTH;
  - a typedef for the valid/stop/data channel bundle;
  - a function computing index width for arbitrary DEPTH.
- Sub-module: elastic_fifo_ctrl holds the indices, count, wrap logic and full/empty flags.
- The top level holds the memory array, output muxing and the bypass path.

Test Plan (all scenarios use DEPTH=3, DATA_WIDTH=8 unless stated):
1. Fill then drain: push 0x11, 0x22, 0x33 with stop_output=1.
   - stop_input=1 and occupancy=3 after the 3rd edge; almost_full=1 from occupancy 2.
   - Release stop_output: outputs 0x11, 0x22, 0x33 in order, then valid_output=0.
2. Simultaneous push/pop at occupancy 2: push 0x44 while popping → occupancy stays 2, no data loss.
3. Wrap-around over 10 continuous transfers with a non-power-of-two depth: values 0..9 emerge in order; the index never reaches 3.
4. Full and popping: push attempt while full with stop_output=0 → stop_input=1, the push is refused, occupancy=2 next cycle.
5. Flush with occupancy=2 concurrent with push 0x55 → occupancy=0 and valid_output=0 next cycle; 0x55 never appears.
6. Async reset mid-stream (reset_n low between edges) → outputs zero immediately.
   - With ELASTIC_FIFO_BYPASS_EN, on empty, valid_input with data 0x66 and stop_output=0 → data_output=0x66 in the same cycle, occupancy stays 0.
